// File: rtl/isp_pkg.sv
// Shared ISP definitions: pad-stage FSM states and pad mode encodings.
package isp_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StTop  = 3'd1,
    StRowL = 3'd2,
    StRowD = 3'd3,
    StRowR = 3'd4,
    StBot  = 3'd5,
    StDone = 3'd6
  } padState_t;

  localparam logic PAD_ZERO  = 1'b0;
  localparam logic PAD_CONST = 1'b1;

endpackage

// File: rtl/frame_border_pad.sv
// Streams one raster frame and surrounds it with a B-pixel border of zero or
// constant pixels so a KxK window filter sees a full padded frame.
module frame_border_pad
  import isp_pkg::*;
#(
  parameter int unsigned WIDTH       = 320,
  parameter int unsigned HEIGHT      = 240,
  parameter int unsigned KERNEL_SIZE = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CHANNELS    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       iStart,
  input  logic                       iMode,
  input  logic [DATA_W-1:0]          iPadValue,
  input  logic                       iValid,
  output logic                       iReady,
  input  logic [DATA_W*CHANNELS-1:0] iData,
  output logic                       oValid,
  input  logic                       oReady,
  output logic [DATA_W*CHANNELS-1:0] oData,
  output logic                       oSof,
  output logic                       oEol,
  output logic                       oDone,
  output logic                       oBusy
);

  localparam int unsigned B  = (KERNEL_SIZE - 1) / 2;
  localparam int unsigned OW = WIDTH + 2 * B;
  localparam int unsigned OH = HEIGHT + 2 * B;
  localparam int unsigned XW = (OW > 1) ? $clog2(OW) : 1;
  localparam int unsigned YW = (OH > 1) ? $clog2(OH) : 1;
  localparam int unsigned PW = DATA_W * CHANNELS;

  // Column/row positions that end each FSM segment.
  localparam logic [XW-1:0] X_LAST    = XW'(OW - 1);
  localparam logic [XW-1:0] X_L_END   = XW'(B - 1);
  localparam logic [XW-1:0] X_D_END   = XW'(B + WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(OH - 1);
  localparam logic [YW-1:0] Y_TOP_END = YW'(B - 1);
  localparam logic [YW-1:0] Y_D_END   = YW'(B + HEIGHT - 1);

  padState_t         stateQ, stateD;
  logic [XW-1:0]     xQ, xD;
  logic [YW-1:0]     yQ, yD;
  logic              modeQ, modeD;
  logic [DATA_W-1:0] padValueQ, padValueD;
  logic              oValidQ, oValidD;
  logic [PW-1:0]     oDataQ, oDataD;
  logic              oSofQ, oSofD;
  logic              oEolQ, oEolD;
  logic              oDoneQ, oDoneD;
  logic              busyQ, busyD;

  logic          load;
  logic          lastCol;
  logic          advance;
  logic [PW-1:0] padPix;

  assign load    = !oValidQ || oReady;
  assign lastCol = (xQ == X_LAST);
  assign padPix  = (modeQ == PAD_CONST) ? {CHANNELS{padValueQ}} : '0;
  assign iReady  = (stateQ == StRowD) && load;

  always_comb begin
    stateD    = stateQ;
    xD        = xQ;
    yD        = yQ;
    modeD     = modeQ;
    padValueD = padValueQ;
    oValidD   = oValidQ;
    oDataD    = oDataQ;
    oSofD     = oSofQ;
    oEolD     = oEolQ;
    oDoneD    = 1'b0;
    busyD     = busyQ;
    advance   = 1'b0;

    unique case (stateQ)
      StIdle: begin
        oValidD = 1'b0;
        oSofD   = 1'b0;
        oEolD   = 1'b0;
        if (iStart) begin
          modeD     = iMode;
          padValueD = iPadValue;
          busyD     = 1'b1;
          xD        = '0;
          yD        = '0;
          stateD    = (B == 0) ? StRowD : StTop;
        end
      end
      StTop: begin
        if (load) begin
          advance = 1'b1;
          oDataD  = padPix;
          if (lastCol && (yQ == Y_TOP_END)) stateD = StRowL;
        end
      end
      StRowL: begin
        if (load) begin
          advance = 1'b1;
          oDataD  = padPix;
          if (xQ == X_L_END) stateD = StRowD;
        end
      end
      StRowD: begin
        if (load) begin
          if (iValid) begin
            advance = 1'b1;
            oDataD  = iData;
            if (xQ == X_D_END) begin
              // Without a border the data row is the whole padded row.
              if (B == 0) stateD = (yQ == Y_LAST) ? StDone : StRowD;
              else        stateD = StRowR;
            end
          end else begin
            oValidD = 1'b0;
            oSofD   = 1'b0;
            oEolD   = 1'b0;
          end
        end
      end
      StRowR: begin
        if (load) begin
          advance = 1'b1;
          oDataD  = padPix;
          if (lastCol) stateD = (yQ == Y_D_END) ? StBot : StRowL;
        end
      end
      StBot: begin
        if (load) begin
          advance = 1'b1;
          oDataD  = padPix;
          if (lastCol && (yQ == Y_LAST)) stateD = StDone;
        end
      end
      StDone: begin
        // Wait for the final beat to leave the output register.
        if (load) begin
          oValidD = 1'b0;
          oSofD   = 1'b0;
          oEolD   = 1'b0;
          oDoneD  = 1'b1;
          busyD   = 1'b0;
          stateD  = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase

    if (advance) begin
      oValidD = 1'b1;
      oSofD   = (xQ == '0) && (yQ == '0);
      oEolD   = lastCol;
      xD      = lastCol ? '0 : xQ + XW'(1);
      if (lastCol) yD = (yQ == Y_LAST) ? '0 : yQ + YW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ    <= StIdle;
      xQ        <= '0;
      yQ        <= '0;
      modeQ     <= PAD_ZERO;
      padValueQ <= '0;
      oValidQ   <= 1'b0;
      oDataQ    <= '0;
      oSofQ     <= 1'b0;
      oEolQ     <= 1'b0;
      oDoneQ    <= 1'b0;
      busyQ     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      xQ        <= xD;
      yQ        <= yD;
      modeQ     <= modeD;
      padValueQ <= padValueD;
      oValidQ   <= oValidD;
      oDataQ    <= oDataD;
      oSofQ     <= oSofD;
      oEolQ     <= oEolD;
      oDoneQ    <= oDoneD;
      busyQ     <= busyD;
    end
  end

  assign oValid = oValidQ;
  assign oData  = oDataQ;
  assign oSof   = oSofQ;
  assign oEol   = oEolQ;
  assign oDone  = oDoneQ;
  assign oBusy  = busyQ;

endmodule
